mem_req_arbiter: RTL
====================

// Module: mem_req_arbiter
// PURPOSE
//  Sits directly downstream of the request unit. Merges its instruction-fetch and
//  data-access requests onto one single-ported RAM port, with data having priority.
//  Returns registered one-cycle ihit/dhit pulses plus load data, and sequences
//  multi-cycle RAM latency.
//  Flags RAM errors and timeouts on a sticky error output.
// PARAMETERS
//  WORD_W   32   data width of load/store paths
//  ADDR_W   32   byte address width
//  TIMEOUT  255  max cycles waiting for ramstate==ACCESS before abort (>=1)
// PORTS
//  CLK        in   1       system clock, rising edge
//  RST        in   1       asynchronous, active-high reset
//  imemREN    in   1       instruction read request (level, held until ihit)
//  imemaddr   in   ADDR_W  instruction address
//  imemload   out  WORD_W  fetched instruction, valid while ihit=1
//  ihit       out  1       one-cycle pulse: instruction fetch complete
//  dmemREN    in   1       data read request (level, held until dhit)
//  dmemWEN    in   1       data write request (level, held until dhit)
//  dmemaddr   in   ADDR_W  data address
//  dmemstore  in   WORD_W  write data
//  dmemload   out  WORD_W  read data, valid while dhit=1
//  dhit       out  1       one-cycle pulse: data access complete
//  ramREN     out  1       RAM read strobe
//  ramWEN     out  1       RAM write strobe
//  ramaddr    out  ADDR_W  RAM address
//  ramstore   out  WORD_W  RAM write data
//  ramload    in   WORD_W  RAM read data, valid when ramstate==ACCESS
//  ramstate   in   2       RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
//  mem_err    out  1       sticky error flag; cleared only by RST
// BEHAVIOUR
//  States:
//   IDLE, DACC, IACC, DHIT, IHIT. Reset -> IDLE.
//  Reset values:
//   All outputs 0. The latched op, address, and store registers are 0.
//  IDLE:
//   - dmemREN|dmemWEN -> DACC. Latch addr, store, and op; WEN wins if both are set.
//   - Otherwise, imemREN -> IACC, latching imemaddr.
//   - Otherwise, stay in IDLE. Data strictly beats instruction in the same cycle.
//  DACC/IACC:
//   - Drive ramREN/ramWEN, ramaddr, and ramstore from the latched values only.
//   - The wait counter clears on entry and increments every cycle.
//  Exits from DACC/IACC:
//   - ramstate==ACCESS: capture ramload into dmemload/imemload -> DHIT/IHIT.
//   - ramstate==ERROR: set mem_err -> IDLE, no hit.
//   - Counter reaches TIMEOUT-1 without ACCESS: set mem_err -> IDLE, no hit.
//   - Requester withdraws (all its request inputs low): drop strobes -> IDLE, no hit.
//  DHIT/IHIT:
//   - Assert dhit/ihit for exactly one cycle; RAM strobes are low; -> IDLE.
//   - The request unit drops its request on that edge, so IDLE does not reissue it.
//  Latency:
//   - The request is seen in IDLE at cycle 0; strobes are driven from cycle 1.
//   - If ACCESS occurs at cycle k, the hit is asserted at cycle k+1.
//   - Minimum: 2 cycles from request to hit.
//  Output timing:
//   - ihit and dhit are never high together.
//   - Load data holds its value after the hit until the next capture.
//  Reset:
//   - Asynchronous RST mid-access returns to IDLE at once.
//   - Strobes drop, hits are 0, and the access is lost.
//  Address checks:
//   - None. Addresses are passed through unmodified; alignment is the requester's job.
// TESTING
//  1. imemREN=1, imemaddr=0x40, ACCESS on 3rd cycle with ramload=0x2402000A
//     -> ramREN=1 with ramaddr=0x40; 1-cycle ihit; imemload=0x2402000A.
//  2. imemREN and dmemWEN both high, dmemaddr=0x80, dmemstore=0xDEAD
//     -> write served first (ramWEN=1, dhit), then the fetch is served with ihit.
//  3. dmemREN held, ramstate stuck BUSY, TIMEOUT=8
//     -> strobes drop after 8 cycles; mem_err=1 and stays 1; no dhit.
//  4. ramstate=ERROR during IACC
//     -> mem_err=1, back to IDLE, no ihit.
//  5. RST pulsed 2 cycles into DACC
//     -> all outputs 0 immediately; a new request afterwards completes normally.
//  6. Request dropped mid-IACC
//     -> no ihit; ramREN=0 next cycle.

Source files
------------

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: merges instruction-fetch and data requests onto one RAM port.
// Data beats instruction, so a pending data access is always issued first.
// Results come back as one-cycle ihit/dhit pulses with registered load data.
// Slow RAM accesses are sequenced with a wait counter, and RAM errors or
// timeouts set the sticky mem_err flag.
//
// Ports:
//   CLK, RST                      clock, async active-high reset
//   imemREN/imemaddr              instruction read request (held until ihit)
//   imemload/ihit                 fetched word and completion pulse
//   dmemREN/dmemWEN/dmemaddr/     data request (held until dhit)
//   dmemstore
//   dmemload/dhit                 load word and completion pulse
//   ramREN/ramWEN/ramaddr/        RAM request, driven from latched values
//   ramstore
//   ramload/ramstate              RAM response (FREE/BUSY/ACCESS/ERROR)
//   mem_err                       sticky error flag, cleared only by RST
`timescale 1ns/1ps

module mem_req_arbiter #(
    parameter int WORD_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              imemREN,
    input  logic [ADDR_W-1:0] imemaddr,
    output logic [WORD_W-1:0] imemload,
    output logic              ihit,
    input  logic              dmemREN,
    input  logic              dmemWEN,
    input  logic [ADDR_W-1:0] dmemaddr,
    input  logic [WORD_W-1:0] dmemstore,
    output logic [WORD_W-1:0] dmemload,
    output logic              dhit,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              mem_err
);

    typedef enum logic [2:0] {
        IDLE,
        DACC,
        IACC,
        DHIT,
        IHIT
    } state_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state;
    logic [ADDR_W-1:0] addrQ;
    logic [WORD_W-1:0] storeQ;
    logic [CNT_W-1:0]  waitCnt;
    logic              reqLive;

    // The RAM address and write data come only from the request latches,
    // so requester-side changes during an access never reach the RAM.
    assign ramaddr  = addrQ;
    assign ramstore = storeQ;

    // The owner of the current access still wants it.
    always_comb begin
        reqLive = 1'b0;
        if (state == DACC) begin
            reqLive = dmemREN | dmemWEN;
        end else if (state == IACC) begin
            reqLive = imemREN;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            addrQ    <= '0;
            storeQ   <= '0;
            waitCnt  <= '0;
            ramREN   <= 1'b0;
            ramWEN   <= 1'b0;
            ihit     <= 1'b0;
            dhit     <= 1'b0;
            imemload <= '0;
            dmemload <= '0;
            mem_err  <= 1'b0;
        end else begin
            ihit <= 1'b0;
            dhit <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (dmemREN | dmemWEN) begin
                        state   <= DACC;
                        addrQ   <= dmemaddr;
                        storeQ  <= dmemstore;
                        waitCnt <= '0;
                        // A write wins when both data strobes are set.
                        ramWEN  <= dmemWEN;
                        ramREN  <= ~dmemWEN;
                    end else if (imemREN) begin
                        state   <= IACC;
                        addrQ   <= imemaddr;
                        storeQ  <= '0;
                        waitCnt <= '0;
                        ramWEN  <= 1'b0;
                        ramREN  <= 1'b1;
                    end
                end
                DACC, IACC: begin
                    if (ramstate == RAM_ACCESS) begin
                        ramREN <= 1'b0;
                        ramWEN <= 1'b0;
                        if (state == DACC) begin
                            dmemload <= ramload;
                            dhit     <= 1'b1;
                            state    <= DHIT;
                        end else begin
                            imemload <= ramload;
                            ihit     <= 1'b1;
                            state    <= IHIT;
                        end
                    end else if (ramstate == RAM_ERROR) begin
                        mem_err <= 1'b1;
                        ramREN  <= 1'b0;
                        ramWEN  <= 1'b0;
                        state   <= IDLE;
                    end else if (!reqLive) begin
                        ramREN <= 1'b0;
                        ramWEN <= 1'b0;
                        state  <= IDLE;
                    end else if (waitCnt == CNT_LAST) begin
                        mem_err <= 1'b1;
                        ramREN  <= 1'b0;
                        ramWEN  <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        waitCnt <= waitCnt + CNT_W'(1);
                    end
                end
                // The requester drops its request on the hit edge, so
                // returning to IDLE cannot reissue the finished access.
                DHIT, IHIT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
